scalar_issue_stage: RTL and testbench

- Issue stage that feeds the scalar ALU.
- Accepts decoded scalar instructions over a valid/ready handshake.
- Reads operands from an internal 32x32 register file, with write-through bypass from the writeback port.
- Tracks RAW/WAW hazards with a pending-bit scoreboard.
- Drives a registered one-entry EX slot carrying the ALU's op_a/op_b/funct3/is_sub/opcode inputs, plus rd and pc for downstream writeback and branch redirect.

---
 rtl/isa_pkg.sv | 40 ++++
 rtl/scalar_scoreboard.sv | 53 +++++
 rtl/scalar_issue_stage.sv | 181 ++++++++++++++++++
 tb/tb_scalar_issue_stage.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// ============================================================================
// isa_pkg
// Scalar major opcodes, the issue packet and EX slot state shared by the
// issue stage and its scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

package isa_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;

   typedef struct packed {
      logic [XLEN_DEF-1:0] op_a;
      logic [XLEN_DEF-1:0] op_b;
      logic [2:0]          funct3;
      logic                is_sub;
      logic [6:0]          opcode;
      logic [4:0]          rd;
      logic                wr_en;
      logic [XLEN_DEF-1:0] pc;
      logic [XLEN_DEF-1:0] imm;
   } issue_pkt_t;

   typedef enum logic [0:0] {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

endpackage

`default_nettype wire

// File: rtl/scalar_scoreboard.sv
// ============================================================================
// scalar_scoreboard
// Pending-write bits for the scalar registers with bypass-aware hazard queries.
// Revision: 1.0
// ============================================================================
`default_nettype none

module scalar_scoreboard
   import isa_pkg::*;
#(
   parameter int NREG = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_set_en,
   input  logic [4:0] i_set_idx,
   input  logic       i_clr_en,
   input  logic [4:0] i_clr_idx,
   input  logic       i_fclr_en,
   input  logic [4:0] i_fclr_idx,
   input  logic [4:0] i_rs1,
   input  logic [4:0] i_rs2,
   input  logic [4:0] i_rd,
   output logic       o_rs1_busy,
   output logic       o_rs2_busy,
   output logic       o_rd_busy
);

   logic [NREG-1:0] r_pend;
   logic [NREG-1:0] w_set;
   logic [NREG-1:0] w_clr;

   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (i_set_en)  w_set[i_set_idx]  = 1'b1;
      if (i_clr_en)  w_clr[i_clr_idx]  = 1'b1;
      if (i_fclr_en) w_clr[i_fclr_idx] = 1'b1;
   end

   // Set is applied after clear so a same-cycle set always wins.
   always_ff @(posedge clk) begin
      if (rst) r_pend <= '0;
      else     r_pend <= (r_pend & ~w_clr) | w_set;
   end

   assign o_rs1_busy = (i_rs1 != 5'd0) && r_pend[i_rs1] && !(i_clr_en && (i_clr_idx == i_rs1));
   assign o_rs2_busy = (i_rs2 != 5'd0) && r_pend[i_rs2] && !(i_clr_en && (i_clr_idx == i_rs2));
   assign o_rd_busy  = r_pend[i_rd] && !(i_clr_en && (i_clr_idx == i_rd));

endmodule

`default_nettype wire

// File: rtl/scalar_issue_stage.sv
// ============================================================================
// scalar_issue_stage
// Issues decoded scalar instructions into a one-entry EX slot with operand
// bypass and hazard stalls. Optional macro SCALAR_ISSUE_PERF_EN adds a
// saturating stall-cycle counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module scalar_issue_stage
   import isa_pkg::*;
#(
   parameter int XLEN        = XLEN_DEF,
   parameter int NREG        = 32,
   parameter int STALL_CNT_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_dec_valid,
   output logic                   o_dec_ready,
   input  logic [6:0]             i_dec_opcode,
   input  logic [2:0]             i_dec_funct3,
   input  logic                   i_dec_funct7_b5,
   input  logic [4:0]             i_dec_rs1,
   input  logic [4:0]             i_dec_rs2,
   input  logic [4:0]             i_dec_rd,
   input  logic [XLEN-1:0]        i_dec_imm,
   input  logic [XLEN-1:0]        i_dec_pc,
   output logic                   o_ex_valid,
   input  logic                   i_ex_ready,
   output logic [XLEN-1:0]        o_ex_op_a,
   output logic [XLEN-1:0]        o_ex_op_b,
   output logic [2:0]             o_ex_funct3,
   output logic                   o_ex_is_sub,
   output logic [6:0]             o_ex_opcode,
   output logic [4:0]             o_ex_rd,
   output logic                   o_ex_wr_en,
   output logic [XLEN-1:0]        o_ex_pc,
   output logic [XLEN-1:0]        o_ex_imm,
   input  logic                   i_wb_valid,
   input  logic [4:0]             i_wb_rd,
   input  logic [XLEN-1:0]        i_wb_data,
   input  logic                   i_flush,
   output logic [STALL_CNT_W-1:0] o_stall_cycles
);

   logic [XLEN-1:0] r_regs [NREG];
   slot_state_t     r_state;
   slot_state_t     w_state_nxt;
   issue_pkt_t      r_pkt;
   issue_pkt_t      w_pkt;
   logic            w_wr;
   logic            w_rs1_busy;
   logic            w_rs2_busy;
   logic            w_rd_busy;
   logic            w_hazard;
   logic            w_slot_free;
   logic            w_dec_ready;
   logic            w_fire;
   logic [XLEN-1:0] w_rs1_val;
   logic [XLEN-1:0] w_rs2_val;

   assign w_wr        = (i_dec_opcode != OP_BRANCH) && (i_dec_opcode != OP_STORE) && (i_dec_rd != 5'd0);
   assign w_hazard    = w_rs1_busy || w_rs2_busy || (w_wr && w_rd_busy);
   assign w_slot_free = (r_state == SLOT_EMPTY) || i_ex_ready;
   assign w_dec_ready = w_slot_free && !w_hazard && !i_flush && !rst;
   assign w_fire      = i_dec_valid && w_dec_ready;

   scalar_scoreboard #(.NREG(NREG)) u_sb (
      .clk        (clk),
      .rst        (rst),
      .i_set_en   (w_fire && w_wr),
      .i_set_idx  (i_dec_rd),
      .i_clr_en   (i_wb_valid),
      .i_clr_idx  (i_wb_rd),
      .i_fclr_en  (i_flush && (r_state == SLOT_FULL) && r_pkt.wr_en),
      .i_fclr_idx (r_pkt.rd),
      .i_rs1      (i_dec_rs1),
      .i_rs2      (i_dec_rs2),
      .i_rd       (i_dec_rd),
      .o_rs1_busy (w_rs1_busy),
      .o_rs2_busy (w_rs2_busy),
      .o_rd_busy  (w_rd_busy)
   );

   // Writeback data forwards to an operand read in the same cycle.
   always_comb begin
      w_rs1_val = r_regs[i_dec_rs1];
      w_rs2_val = r_regs[i_dec_rs2];
      if (i_dec_rs1 == 5'd0)                            w_rs1_val = '0;
      else if (i_wb_valid && (i_wb_rd == i_dec_rs1))    w_rs1_val = i_wb_data;
      if (i_dec_rs2 == 5'd0)                            w_rs2_val = '0;
      else if (i_wb_valid && (i_wb_rd == i_dec_rs2))    w_rs2_val = i_wb_data;
   end

   always_comb begin
      w_pkt        = '0;
      w_pkt.op_a   = w_rs1_val;
      w_pkt.op_b   = w_rs2_val;
      w_pkt.funct3 = i_dec_funct3;
      w_pkt.is_sub = i_dec_funct7_b5 &&
                     ((i_dec_opcode == OP_OP) || ((i_dec_opcode == OP_IMM) && (i_dec_funct3 == 3'b101)));
      w_pkt.opcode = i_dec_opcode;
      w_pkt.rd     = i_dec_rd;
      w_pkt.wr_en  = w_wr;
      w_pkt.pc     = i_dec_pc;
      w_pkt.imm    = i_dec_imm;
      case (i_dec_opcode)
         OP_IMM, OP_LOAD, OP_STORE: w_pkt.op_b = i_dec_imm;
         OP_LUI: begin
            w_pkt.op_a   = '0;
            w_pkt.op_b   = i_dec_imm;
            w_pkt.funct3 = 3'b000;
         end
         OP_AUIPC: begin
            w_pkt.op_a   = i_dec_pc;
            w_pkt.op_b   = i_dec_imm;
            w_pkt.funct3 = 3'b000;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= SLOT_EMPTY;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         SLOT_EMPTY: if (w_fire) w_state_nxt = SLOT_FULL;
         SLOT_FULL:  if (i_ex_ready && !w_fire) w_state_nxt = SLOT_EMPTY;
         default:    w_state_nxt = SLOT_EMPTY;
      endcase
      if (i_flush) w_state_nxt = SLOT_EMPTY;
   end

   always_ff @(posedge clk) begin
      if (rst)         r_pkt <= '0;
      else if (w_fire) r_pkt <= w_pkt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      end else if (i_wb_valid && (i_wb_rd != 5'd0)) begin
         r_regs[i_wb_rd] <= i_wb_data;
      end
   end

`ifdef SCALAR_ISSUE_PERF_EN
   logic [STALL_CNT_W-1:0] r_stall_cnt;

   always_ff @(posedge clk) begin
      if (rst)
         r_stall_cnt <= '0;
      else if (i_dec_valid && !w_dec_ready && (r_stall_cnt != '1))
         r_stall_cnt <= r_stall_cnt + 1'b1;
   end

   assign o_stall_cycles = r_stall_cnt;
`else
   assign o_stall_cycles = '0;
`endif

   assign o_dec_ready = w_dec_ready;
   assign o_ex_valid  = (r_state == SLOT_FULL);
   assign o_ex_op_a   = r_pkt.op_a;
   assign o_ex_op_b   = r_pkt.op_b;
   assign o_ex_funct3 = r_pkt.funct3;
   assign o_ex_is_sub = r_pkt.is_sub;
   assign o_ex_opcode = r_pkt.opcode;
   assign o_ex_rd     = r_pkt.rd;
   assign o_ex_wr_en  = r_pkt.wr_en;
   assign o_ex_pc     = r_pkt.pc;
   assign o_ex_imm    = r_pkt.imm;

endmodule

`default_nettype wire

// File: tb/tb_scalar_issue_stage.sv
// ============================================================================
// tb_scalar_issue_stage
// Self-checking bench: vector table plus hand sequences for stalls and flush.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_scalar_issue_stage;
   import isa_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        dec_valid, dec_ready;
   logic [6:0]  dec_opcode;
   logic [2:0]  dec_funct3;
   logic        dec_funct7_b5;
   logic [4:0]  dec_rs1, dec_rs2, dec_rd;
   logic [31:0] dec_imm, dec_pc;
   logic        ex_valid, ex_ready;
   logic [31:0] ex_op_a, ex_op_b, ex_pc, ex_imm;
   logic [2:0]  ex_funct3;
   logic        ex_is_sub, ex_wr_en;
   logic [6:0]  ex_opcode;
   logic [4:0]  ex_rd;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        flush;
   logic [31:0] stall_cycles;

   always #5 clk = ~clk;

   scalar_issue_stage dut (
      .clk(clk), .rst(rst),
      .i_dec_valid(dec_valid), .o_dec_ready(dec_ready),
      .i_dec_opcode(dec_opcode), .i_dec_funct3(dec_funct3), .i_dec_funct7_b5(dec_funct7_b5),
      .i_dec_rs1(dec_rs1), .i_dec_rs2(dec_rs2), .i_dec_rd(dec_rd),
      .i_dec_imm(dec_imm), .i_dec_pc(dec_pc),
      .o_ex_valid(ex_valid), .i_ex_ready(ex_ready),
      .o_ex_op_a(ex_op_a), .o_ex_op_b(ex_op_b), .o_ex_funct3(ex_funct3),
      .o_ex_is_sub(ex_is_sub), .o_ex_opcode(ex_opcode), .o_ex_rd(ex_rd),
      .o_ex_wr_en(ex_wr_en), .o_ex_pc(ex_pc), .o_ex_imm(ex_imm),
      .i_wb_valid(wb_valid), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
      .i_flush(flush), .o_stall_cycles(stall_cycles)
   );

   typedef struct {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        b30;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] imm, pc;
      logic [31:0] ea, eb;
      logic [2:0]  ef3;
      logic        esub, ewr;
   } vec_t;

   typedef struct {
      logic [31:0] a, b, pc, imm;
      logic [2:0]  f3;
      logic        sub;
      logic [6:0]  op;
      logic [4:0]  rd;
      logic        wr;
   } exp_t;

   exp_t exp_q[$];
   exp_t last;
   vec_t tbl[11];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic b30,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [31:0] imm, input logic [31:0] pc);
      dec_valid = 1'b1; dec_opcode = op; dec_funct3 = f3; dec_funct7_b5 = b30;
      dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd; dec_imm = imm; dec_pc = pc;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                       input logic sub, input logic wr);
      exp_t e;
      e.a = a; e.b = b; e.f3 = f3; e.sub = sub; e.wr = wr;
      e.op = dec_opcode; e.rd = dec_rd; e.pc = dec_pc; e.imm = dec_imm;
      exp_q.push_back(e);
   endtask

   task automatic compare_last(input string tag);
      chk({tag, ".valid"}, {31'd0, ex_valid}, 32'd1);
      chk({tag, ".op_a"}, ex_op_a, last.a);
      chk({tag, ".op_b"}, ex_op_b, last.b);
      chk({tag, ".funct3"}, {29'd0, ex_funct3}, {29'd0, last.f3});
      chk({tag, ".is_sub"}, {31'd0, ex_is_sub}, {31'd0, last.sub});
      chk({tag, ".opcode"}, {25'd0, ex_opcode}, {25'd0, last.op});
      chk({tag, ".rd"}, {27'd0, ex_rd}, {27'd0, last.rd});
      chk({tag, ".wr_en"}, {31'd0, ex_wr_en}, {31'd0, last.wr});
      chk({tag, ".pc"}, ex_pc, last.pc);
      chk({tag, ".imm"}, ex_imm, last.imm);
   endtask

   task automatic check_ex(input string tag);
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: no expected packet queued, got ex_valid=%0b", tag, ex_valid);
      end else begin
         last = exp_q.pop_front();
         compare_last(tag);
      end
   endtask

   task automatic wb(input logic [4:0] rd, input logic [31:0] data);
      wb_valid = 1'b1; wb_rd = rd; wb_data = data;
      tick();
      wb_valid = 1'b0;
   endtask

   initial begin
      //         op         f3     b30 rs1 rs2 rd  imm            pc          ea            eb            ef3    sub wr
      tbl[0]  = '{OP_IMM,    3'b000, 0, 0, 0, 1,  32'd5,        32'h100, 32'd0,        32'd5,        3'b000, 0, 1};
      tbl[1]  = '{OP_OP,     3'b000, 0, 5, 6, 10, 32'd0,        32'h104, 32'd100,      32'd3,        3'b000, 0, 1};
      tbl[2]  = '{OP_OP,     3'b000, 1, 5, 6, 11, 32'd0,        32'h108, 32'd100,      32'd3,        3'b000, 1, 1};
      tbl[3]  = '{OP_IMM,    3'b101, 1, 7, 0, 12, 32'h404,      32'h10c, 32'hFFFFFFF0, 32'h404,      3'b101, 1, 1};
      tbl[4]  = '{OP_IMM,    3'b000, 1, 5, 0, 13, 32'hFFFFFFFF, 32'h110, 32'd100,      32'hFFFFFFFF, 3'b000, 0, 1};
      tbl[5]  = '{OP_LUI,    3'b111, 0, 5, 6, 14, 32'h12345000, 32'h114, 32'd0,        32'h12345000, 3'b000, 0, 1};
      tbl[6]  = '{OP_AUIPC,  3'b101, 1, 5, 6, 15, 32'h1000,     32'h200, 32'h200,      32'h1000,     3'b000, 0, 1};
      tbl[7]  = '{OP_BRANCH, 3'b000, 1, 5, 6, 9,  32'h20,       32'h204, 32'd100,      32'd3,        3'b000, 0, 0};
      tbl[8]  = '{OP_STORE,  3'b010, 0, 6, 5, 3,  32'd8,        32'h208, 32'd3,        32'd8,        3'b010, 0, 0};
      tbl[9]  = '{OP_LOAD,   3'b010, 0, 5, 0, 16, 32'd4,        32'h20c, 32'd100,      32'd4,        3'b010, 0, 1};
      tbl[10] = '{OP_OP,     3'b000, 0, 5, 5, 0,  32'd0,        32'h210, 32'd100,      32'd100,      3'b000, 0, 0};

      rst = 1'b1; ex_ready = 1'b1; flush = 1'b0;
      wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
      drive(OP_IMM, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1, 32'd5, 32'h0);

      tick(); #1;
      chk("rst.dec_ready", {31'd0, dec_ready}, 32'd0);
      chk("rst.ex_valid", {31'd0, ex_valid}, 32'd0);
      rst = 1'b0; dec_valid = 1'b0;
      tick();
      chk("rst.ex_op_b", ex_op_b, 32'd0);
      chk("rst.ex_rd", {27'd0, ex_rd}, 32'd0);
      chk("rst.stall", stall_cycles, 32'd0);

      wb(5'd5, 32'd100);
      wb(5'd6, 32'd3);
      wb(5'd7, 32'hFFFFFFF0);

      // RAW stall for five cycles, released by a same-cycle writeback.
      drive(OP_OP, 3'b000, 1'b0, 5'd5, 5'd6, 5'd2, 32'd0, 32'h40);
      #1 chk("raw.first_ready", {31'd0, dec_ready}, 32'd1);
      push(32'd100, 32'd3, 3'b000, 1'b0, 1'b1);
      tick(); check_ex("raw.first");
      drive(OP_OP, 3'b000, 1'b0, 5'd2, 5'd2, 5'd3, 32'd0, 32'h44);
      for (int i = 0; i < 5; i++) begin
         #1 chk("raw.stall_ready", {31'd0, dec_ready}, 32'd0);
         tick();
      end
      wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'd7;
      #1 chk("raw.bypass_ready", {31'd0, dec_ready}, 32'd1);
      push(32'd7, 32'd7, 3'b000, 1'b0, 1'b1);
      tick();
      wb_valid = 1'b0;
      check_ex("raw.bypass");
`ifdef SCALAR_ISSUE_PERF_EN
      chk("raw.stall_cycles", stall_cycles, 32'd5);
`else
      chk("raw.stall_cycles", stall_cycles, 32'd0);
`endif

      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].op, tbl[i].f3, tbl[i].b30, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].imm, tbl[i].pc);
         #1 chk($sformatf("vec%0d.ready", i), {31'd0, dec_ready}, 32'd1);
         push(tbl[i].ea, tbl[i].eb, tbl[i].ef3, tbl[i].esub, tbl[i].ewr);
         tick();
         check_ex($sformatf("vec%0d", i));
      end
      dec_valid = 1'b0;
      tick();
      chk("drain.ex_valid", {31'd0, ex_valid}, 32'd0);

      // Backpressure: EX held for three cycles.
      drive(OP_IMM, 3'b000, 1'b0, 5'd5, 5'd0, 5'd20, 32'd1, 32'h300);
      #1 push(32'd100, 32'd1, 3'b000, 1'b0, 1'b1);
      tick(); check_ex("bp.first");
      ex_ready = 1'b0;
      drive(OP_IMM, 3'b000, 1'b0, 5'd6, 5'd0, 5'd21, 32'd2, 32'h304);
      for (int i = 0; i < 3; i++) begin
         #1 chk("bp.hold_ready", {31'd0, dec_ready}, 32'd0);
         tick();
         compare_last("bp.hold");
      end
      ex_ready = 1'b1;
      #1 chk("bp.release_ready", {31'd0, dec_ready}, 32'd1);
      push(32'd3, 32'd2, 3'b000, 1'b0, 1'b1);
      tick(); check_ex("bp.second");

      // Flush clears the slot and the pending bit of its destination.
      drive(OP_IMM, 3'b000, 1'b0, 5'd5, 5'd0, 5'd4, 32'd0, 32'h400);
      #1 push(32'd100, 32'd0, 3'b000, 1'b0, 1'b1);
      tick(); check_ex("flush.victim");
      ex_ready = 1'b0; flush = 1'b1;
      drive(OP_OP, 3'b000, 1'b0, 5'd4, 5'd4, 5'd22, 32'd0, 32'h404);
      #1 chk("flush.ready", {31'd0, dec_ready}, 32'd0);
      tick();
      flush = 1'b0; ex_ready = 1'b1;
      chk("flush.ex_valid", {31'd0, ex_valid}, 32'd0);
      #1 chk("flush.reissue_ready", {31'd0, dec_ready}, 32'd1);
      push(32'd0, 32'd0, 3'b000, 1'b0, 1'b1);
      tick(); check_ex("flush.reissue");

      // Writeback to x0 never reaches an operand.
      wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'd99;
      drive(OP_OP, 3'b000, 1'b0, 5'd0, 5'd0, 5'd25, 32'd0, 32'h500);
      #1 push(32'd0, 32'd0, 3'b000, 1'b0, 1'b1);
      tick(); wb_valid = 1'b0; check_ex("x0.bypass");
      drive(OP_OP, 3'b000, 1'b0, 5'd0, 5'd0, 5'd26, 32'd0, 32'h504);
      #1 push(32'd0, 32'd0, 3'b000, 1'b0, 1'b1);
      tick(); check_ex("x0.regfile");

      // WAW stall, then set-wins when issue and writeback hit the same register.
      drive(OP_IMM, 3'b000, 1'b0, 5'd5, 5'd0, 5'd24, 32'd0, 32'h600);
      #1 push(32'd100, 32'd0, 3'b000, 1'b0, 1'b1);
      tick(); check_ex("waw.first");
      drive(OP_IMM, 3'b000, 1'b0, 5'd6, 5'd0, 5'd24, 32'd0, 32'h604);
      #1 chk("waw.ready", {31'd0, dec_ready}, 32'd0);
      tick();
      wb_valid = 1'b1; wb_rd = 5'd24; wb_data = 32'd55;
      #1 chk("waw.release_ready", {31'd0, dec_ready}, 32'd1);
      push(32'd3, 32'd0, 3'b000, 1'b0, 1'b1);
      tick(); wb_valid = 1'b0; check_ex("waw.second");
      drive(OP_OP, 3'b000, 1'b0, 5'd24, 5'd0, 5'd27, 32'd0, 32'h608);
      #1 chk("setwins.ready", {31'd0, dec_ready}, 32'd0);
      tick();
      wb_valid = 1'b1; wb_rd = 5'd24; wb_data = 32'd66;
      #1 push(32'd66, 32'd0, 3'b000, 1'b0, 1'b1);
      tick(); wb_valid = 1'b0; check_ex("setwins.issue");

      // Mid-operation reset drops the slot and all pending bits.
      drive(OP_OP, 3'b000, 1'b0, 5'd3, 5'd0, 5'd28, 32'd0, 32'h700);
      #1 chk("midrst.pre_ready", {31'd0, dec_ready}, 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst.ex_valid", {31'd0, ex_valid}, 32'd0);
      #1 chk("midrst.ready", {31'd0, dec_ready}, 32'd1);
      push(32'd0, 32'd0, 3'b000, 1'b0, 1'b1);
      tick(); check_ex("midrst.issue");
      dec_valid = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
